// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor sequencer driving one external 1-bit full-subtractor cell.
// Operands are consumed LSB first, one bit per clock.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  // Holds the WIDTH-1 result bits produced so far; the final bit comes straight from the cell.
  logic [WIDTH-2:0] d_sh_q;
  logic             brw_q;
  logic [CntW-1:0]  cnt_q;
  logic             ready_q, busy_q, done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            brw_q   <= bin_in;
            cnt_q   <= '0;
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          d_sh_q <= (WIDTH-1)'({fs_d, d_sh_q} >> 1);
          brw_q  <= fs_bout;
          if (cnt_q == CntLast) begin
            cnt_q    <= '0;
            diff_q   <= {fs_d, d_sh_q};
            borrow_q <= fs_bout;
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

  // Cell inputs are gated so the cell sees zeros outside RUN.
  assign fs_a   = busy_q & a_sh_q[0];
  assign fs_b   = busy_q & b_sh_q[0];
  assign fs_bin = busy_q & brw_q;

endmodule
